lif_neuron_array: RTL and testbench

//  Parametrised array of N_CH leaky integrate-and-fire neurons sharing one

---
 rtl/lif_neuron_array.sv | 165 ++++++++++++++++
 tb/tb_lif_neuron_array.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/lif_neuron_array.sv
// Array of N_CH leaky integrate-and-fire neurons. One shared update datapath
// walks the channels one per clock; per-channel registers live in lif_lane.

module lif_lane #(
  parameter int WIDTH = 8,
  parameter int RW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             upd,
  input  logic             fire,
  input  logic [WIDTH-1:0] new_state,
  input  logic [RW-1:0]    new_ref,
  input  logic             thr_we,
  input  logic [WIDTH-1:0] thr_data,
  output logic [WIDTH-1:0] state,
  output logic [RW-1:0]    refrac,
  output logic [WIDTH-1:0] thr,
  output logic             spike_sh
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= '0;
      refrac   <= '0;
      spike_sh <= 1'b0;
    end else if (upd) begin
      state    <= new_state;
      refrac   <= new_ref;
      spike_sh <= fire;
    end
  end

  // Registered threshold: an update in the same cycle as a write still
  // compares against the old value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       thr <= {1'b1, {(WIDTH-1){1'b0}}};
    else if (thr_we) thr <= thr_data;
  end

endmodule

module lif_neuron_array #(
  parameter int N_CH       = 4,
  parameter int WIDTH      = 8,
  parameter int LEAK_SHIFT = 1,
  parameter int REFRAC     = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_CH*WIDTH-1:0]    in_current,
  input  logic                     thr_we,
  input  logic [$clog2(N_CH)-1:0]  thr_addr,
  input  logic [WIDTH-1:0]         thr_data,
  output logic                     spike_valid,
  output logic [N_CH-1:0]          spike,
  output logic [N_CH*WIDTH-1:0]    state_out
);

  localparam int AW = $clog2(N_CH);
  localparam int RW = (REFRAC < 2) ? 1 : $clog2(REFRAC + 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} fsm_t;

  fsm_t fsm, fsm_nx;
  logic [AW-1:0] idx;
  logic          last;

  logic [N_CH-1:0][WIDTH-1:0] cur_buf;
  logic [N_CH-1:0][WIDTH-1:0] st;
  logic [N_CH-1:0][WIDTH-1:0] thr;
  logic [N_CH-1:0][RW-1:0]    rf;
  logic [N_CH-1:0]            sh;
  logic [N_CH-1:0]            shadow_nx;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] v;
  logic [WIDTH-1:0] new_state;
  logic [RW-1:0]    new_ref;
  logic             fire;

  assign last      = (idx == AW'(N_CH - 1));
  assign in_ready  = (fsm == IDLE);
  assign state_out = st;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fsm <= IDLE;
    else       fsm <= fsm_nx;
  end

  always_comb begin
    fsm_nx = fsm;
    case (fsm)
      IDLE:    if (in_valid) fsm_nx = SCAN;
      SCAN:    if (last)     fsm_nx = DONE;
      DONE:                  fsm_nx = IDLE;
      default:               fsm_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx         <= '0;
      cur_buf     <= '0;
      spike       <= '0;
      spike_valid <= 1'b0;
    end else begin
      spike_valid <= 1'b0;
      if (fsm == IDLE && in_valid) begin
        cur_buf <= in_current;
        idx     <= '0;
      end else if (fsm == SCAN) begin
        idx <= idx + AW'(1);
        // Last channel's result is folded in here so spike is already
        // valid during the DONE cycle when spike_valid pulses.
        if (last) begin
          spike       <= shadow_nx;
          spike_valid <= 1'b1;
        end
      end
    end
  end

  // Shared update datapath for the channel selected by idx.
  always_comb begin
    sum       = {1'b0, cur_buf[idx]} + {1'b0, st[idx] >> LEAK_SHIFT};
    v         = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
    fire      = 1'b0;
    new_state = v;
    new_ref   = '0;
    if (rf[idx] != '0) begin
      new_state = '0;
      new_ref   = rf[idx] - RW'(1);
    end else if (v >= thr[idx]) begin
      fire      = 1'b1;
      new_state = '0;
      new_ref   = RW'(REFRAC);
    end
  end

  always_comb begin
    shadow_nx      = sh;
    shadow_nx[idx] = fire;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    lif_lane #(.WIDTH(WIDTH), .RW(RW)) u_lane (
      .clk       (clk),
      .reset     (reset),
      .upd       ((fsm == SCAN) && (idx == AW'(i))),
      .fire      (fire),
      .new_state (new_state),
      .new_ref   (new_ref),
      .thr_we    (thr_we && (thr_addr == AW'(i))),
      .thr_data  (thr_data),
      .state     (st[i]),
      .refrac    (rf[i]),
      .thr       (thr[i]),
      .spike_sh  (sh[i])
    );
  end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Bench for lif_neuron_array: constant tables for the documented scenarios,
// hand sequences for timing/race/reset corners, and a random run vs a model.
module tb_lif_neuron_array;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, thr_we, spike_valid;
  logic [31:0] in_current, state_out;
  logic [1:0]  thr_addr;
  logic [7:0]  thr_data;
  logic [3:0]  spike;

  lif_neuron_array #(.N_CH(4), .WIDTH(8), .LEAK_SHIFT(1), .REFRAC(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_current(in_current), .thr_we(thr_we), .thr_addr(thr_addr),
    .thr_data(thr_data), .spike_valid(spike_valid), .spike(spike),
    .state_out(state_out)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model: plain integer arithmetic per frame.
  int m_st[4], m_rf[4], m_thr[4];

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin m_st[c] = 0; m_rf[c] = 0; m_thr[c] = 128; end
  endtask

  task automatic model_frame(input logic [31:0] cur, output logic [31:0] est, output logic [3:0] espk);
    est = '0; espk = '0;
    for (int c = 0; c < 4; c++) begin
      int v;
      if (m_rf[c] > 0) begin
        m_st[c] = 0; m_rf[c] = m_rf[c] - 1;
      end else begin
        v = int'(cur[c*8 +: 8]) + m_st[c] / 2;
        if (v > 255) v = 255;
        if (v >= m_thr[c]) begin espk[c] = 1'b1; m_st[c] = 0; m_rf[c] = 2; end
        else m_st[c] = v;
      end
      est[c*8 +: 8] = 8'(m_st[c]);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; @(negedge clk); reset = 1'b0; @(negedge clk);
    model_reset();
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!spike_valid && n < 20) begin @(negedge clk); n++; end
    check(name, spike_valid, 1'b1);
  endtask

  // Called at a negedge; returns at the negedge of the DONE cycle.
  task automatic run_frame(input logic [31:0] cur, output logic [3:0] spk, output logic [31:0] st);
    int n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    in_current = cur; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    wait_done("frame_done");
    spk = spike; st = state_out;
  endtask

  task automatic thr_write(input logic [1:0] a, input logic [7:0] d);
    thr_we = 1'b1; thr_addr = a; thr_data = d;
    @(negedge clk); thr_we = 1'b0;
  endtask

  typedef struct { logic [31:0] cur; logic [31:0] st; logic [3:0] spk; } vec_t;
  vec_t tbl[7];

  logic [31:0] st, est;
  logic [3:0]  spk, espk;
  int acc_q[$], sv_q[$];
  int svc;

  initial begin
    tbl[0] = '{32'd70, 32'd70,  4'b0000};
    tbl[1] = '{32'd70, 32'd105, 4'b0000};
    tbl[2] = '{32'd70, 32'd122, 4'b0000};
    tbl[3] = '{32'd70, 32'd0,   4'b0001};
    tbl[4] = '{32'd70, 32'd0,   4'b0000};
    tbl[5] = '{32'd70, 32'd0,   4'b0000};
    tbl[6] = '{32'd70, 32'd70,  4'b0000};

    reset = 1'b0; in_valid = 1'b0; thr_we = 1'b0; thr_addr = '0;
    thr_data = '0; in_current = '0;

    // Reset values, during and after reset
    @(negedge clk); reset = 1'b1; @(negedge clk);
    check("rst_state", state_out, 0);
    check("rst_spike", spike, 0);
    check("rst_spike_valid", spike_valid, 0);
    check("rst_in_ready", in_ready, 1);
    reset = 1'b0; @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    run_frame(32'd127, spk, st);
    check("below_thr_spike", spk, 4'b0000);
    check("below_thr_state", st, 32'd127);

    // Integrate / fire / refractory
    do_reset();
    for (int i = 0; i < 7; i++) begin
      run_frame(tbl[i].cur, spk, st);
      check($sformatf("integ_spike_f%0d", i + 1), spk, tbl[i].spk);
      check($sformatf("integ_state_f%0d", i + 1), st, tbl[i].st);
    end

    // Saturation against threshold 255
    do_reset();
    thr_write(2'd1, 8'd255);
    run_frame(32'd200 << 8, spk, st);
    check("sat_f1_spike", spk, 4'b0000);
    check("sat_f1_state", st, 32'd200 << 8);
    run_frame(32'd200 << 8, spk, st);
    check("sat_f2_spike", spk, 4'b0010);
    check("sat_f2_state", st, 32'd0);

    // Throughput with in_valid held high
    do_reset();
    in_current = '0; in_valid = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (in_valid && in_ready) acc_q.push_back(cyc);
      if (spike_valid) sv_q.push_back(cyc);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("tp_accepts", acc_q.size(), 7);
    check("tp_spike_valids", sv_q.size(), 6);
    for (int k = 1; k < acc_q.size(); k++)
      check($sformatf("tp_gap%0d", k), acc_q[k] - acc_q[k-1], 6);
    for (int k = 0; k < sv_q.size() && k < acc_q.size(); k++)
      check($sformatf("tp_latency%0d", k), sv_q[k] - acc_q[k], 5);
    repeat (8) @(negedge clk);

    // Threshold write racing the ch2 update
    do_reset();
    in_current = 32'd50 << 16; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;   // idx 0
    @(negedge clk);                    // idx 1
    @(negedge clk);                    // idx 2
    thr_write(2'd2, 8'd10);
    wait_done("race_done");
    check("race_f1_spike", spike, 4'b0000);
    check("race_f1_state", state_out, 32'd50 << 16);
    @(negedge clk);
    run_frame(32'd50 << 16, spk, st);
    check("race_f2_spike", spk, 4'b0100);
    check("race_f2_state", st, 32'd0);

    // Reset in the middle of a scan
    do_reset();
    thr_write(2'd3, 8'd20);
    run_frame({8'd0, 8'd60, 8'd200, 8'd60}, spk, st);
    check("pre_abort_spike", spk, 4'b0010);
    @(negedge clk);
    in_current = '0; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1; @(negedge clk);
    check("abort_state", state_out, 0);
    check("abort_spike", spike, 0);
    check("abort_spike_valid", spike_valid, 0);
    check("abort_in_ready", in_ready, 1);
    reset = 1'b0;
    svc = 0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (spike_valid) svc++; end
    check("abort_no_spike_valid", svc, 0);
    run_frame(32'd127 << 24, spk, st);
    check("abort_thr_restored_spike", spk, 4'b0000);
    check("abort_thr_restored_state", st, 32'd127 << 24);

    // Random frames and threshold writes vs model
    do_reset();
    for (int f = 0; f < 60; f++) begin
      logic [31:0] cur;
      if ($urandom_range(0, 3) == 0) begin
        logic [1:0] a;
        logic [7:0] d;
        a = 2'($urandom_range(0, 3));
        d = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
        thr_write(a, d);
        m_thr[a] = int'(d);
      end
      for (int c = 0; c < 4; c++) cur[c*8 +: 8] = 8'($urandom_range(0, 255));
      run_frame(cur, spk, st);
      model_frame(cur, est, espk);
      check($sformatf("rand_spike_f%0d", f), spk, espk);
      check($sformatf("rand_state_f%0d", f), st, est);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
